// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - shared types and constants for the seven-segment scan scheduler
package sevseg_pkg;

   typedef enum logic {
      SHOW_A = 1'b0,
      SHOW_B = 1'b1
   } state_t;

   localparam int DIGITS  = 4;
   localparam int DIGIT_W = 4;
   localparam int WORD_W  = DIGITS * DIGIT_W;

   // Counter width for a modulus of v, never narrower than one bit.
   function automatic int min_one_clog2(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/sevseg_refresh_gen.sv
// rtl/sevseg_refresh_gen.sv - refresh prescaler and digit-select counter
module sevseg_refresh_gen
   import sevseg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst,
   output logic       tick,
   output logic [1:0] digit_sel,
   output logic       frame_end
);

   localparam int              PW         = min_one_clog2(REFRESH_DIV);
   localparam logic [PW-1:0]   LAST_PRE   = PW'(REFRESH_DIV - 1);
   localparam logic [1:0]      LAST_DIGIT = 2'(DIGITS - 1);

   logic [PW-1:0] prescale;

   always_ff @(posedge clk) begin
      if (rst) begin
         prescale  <= '0;
         digit_sel <= '0;
      end else if (tick) begin
         prescale  <= '0;
         digit_sel <= digit_sel + 2'd1;
      end else begin
         prescale  <= prescale + 1'b1;
      end
   end

   assign tick      = (prescale == LAST_PRE);
   assign frame_end = tick && (digit_sel == LAST_DIGIT);

endmodule

// File: rtl/sevseg_scan_sched.sv
// rtl/sevseg_scan_sched.sv - frame-synchronous source arbiter feeding the display driver
module sevseg_scan_sched
   import sevseg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int HOLD_FRAMES = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a_data,
   input  logic        b_req,
   input  logic [15:0] b_data,
   output logic        b_ack,
   output logic        b_done,
   output logic [1:0]  digit_sel,
   output logic [15:0] disp_data,
   output logic        frame_end
);

   localparam int            HW        = min_one_clog2(HOLD_FRAMES);
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES - 1);

   logic tick;
   logic frame_end_i;
   logic advance;

   state_t            state_q, state_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [WORD_W-1:0] disp_q, disp_d;
   logic              ack_q, ack_d;
   logic              done_q, done_d;

   sevseg_refresh_gen #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_refresh (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .digit_sel (digit_sel),
      .frame_end (frame_end_i)
   );

   // All display/handshake updates are confined to the frame boundary so a frame never tears.
   assign advance = tick && frame_end_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SHOW_A;
         hold_q  <= '0;
         disp_q  <= '0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         disp_q  <= disp_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      disp_d  = disp_q;
      ack_d   = 1'b0;
      done_d  = 1'b0;
      if (advance) begin
         case (state_q)
            SHOW_A: begin
               if (b_req) begin
                  disp_d  = b_data;
                  ack_d   = 1'b1;
                  hold_d  = HOLD_INIT;
                  state_d = SHOW_B;
               end else begin
                  disp_d = a_data;
               end
            end
            SHOW_B: begin
               // b_req is deliberately ignored here; A gets a full frame after b_done.
               if (hold_q != '0) begin
                  hold_d = hold_q - 1'b1;
               end else begin
                  disp_d  = a_data;
                  done_d  = 1'b1;
                  state_d = SHOW_A;
               end
            end
            default: state_d = SHOW_A;
         endcase
      end
   end

   assign disp_data = disp_q;
   assign b_ack     = ack_q;
   assign b_done    = done_q;
   assign frame_end = frame_end_i;

endmodule
